// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
// Holds the scan FSM state type, matrix size, idle drive and key-code helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  localparam int         NUM_ROWS   = 4;
  localparam int         NUM_COLS   = 4;
  localparam logic [3:0] ROW0_DRIVE = 4'b1110;
  localparam logic [7:0] KEY_NONE   = 8'h00;

  // true when exactly one active-low column is pulled down
  function automatic logic one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] i;
    i = '0;
    for (int k = 0; k < NUM_COLS; k++)
      if (!v[k]) i = 2'(k);
    return i;
  endfunction

  // row r -> bit 4+r, column c -> bit 3-c
  function automatic logic [7:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] rb;
    logic [3:0] cb;
    rb = 4'b0001 << r;
    cb = 4'b1000 >> c;
    return {rb, cb};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key code bundle from the scanner to keypad_decoder.
// keypad_val = one-hot {row,col}; key_valid = update strobe; key_held = key down.
interface keypad_scanner_if;

  logic [7:0] keypad_val;
  logic       key_valid;
  logic       key_held;

  modport master (
    output keypad_val,
    output key_valid,
    output key_held
  );

  modport slave (
    input keypad_val,
    input key_valid,
    input key_held
  );

endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: W-bit two-flop synchronizer, async active-low reset to ones.
// Ports: clk, reset_n, d (async in), q (synchronized out).
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, debounce and one-hot key code producer.
// Ports: clk, reset_n, col_n (in), row_n (out), kp (keypad_scanner_if.master).
// Optional KEYPAD_AUTOREPEAT_EN: re-strobe key_valid every REPEAT_CNT while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4096,
  parameter int DEBOUNCE_CNT = 65536,
  parameter int REPEAT_CNT   = 2000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_COLS-1:0]      col_n,
  output logic [NUM_ROWS-1:0]      row_n,
  keypad_scanner_if.master         kp
);

  localparam int CMAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

  logic [NUM_COLS-1:0] col_s;

  scan_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    row, row_nx;
  logic [1:0]    col, col_nx;
  logic [3:0]    pat, pat_n;
  logic [7:0]    kval, kval_n;
  logic          kvalid, kvalid_n;
  logic          kheld, kheld_n;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CNT > 2) ? $clog2(REPEAT_CNT) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rcnt, rcnt_n;
`else
  logic unused_repeat;
  assign unused_repeat = |REPEAT_CNT;
`endif

  keypad_sync #(.W(NUM_COLS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (col_n),
    .q       (col_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= SCAN;
      cnt    <= '0;
      row    <= '0;
      col    <= '0;
      pat    <= '1;
      kval   <= KEY_NONE;
      kvalid <= 1'b0;
      kheld  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rcnt   <= '0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      row    <= row_nx;
      col    <= col_nx;
      pat    <= pat_n;
      kval   <= kval_n;
      kvalid <= kvalid_n;
      kheld  <= kheld_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rcnt   <= rcnt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    row_nx   = row;
    col_nx   = col;
    pat_n    = pat;
    kval_n   = kval;
    kvalid_n = 1'b0;
    kheld_n  = kheld;
`ifdef KEYPAD_AUTOREPEAT_EN
    rcnt_n   = rcnt;
`endif
    unique case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          // ghosted or idle rows just move on
          if (one_low(col_s)) begin
            state_n = DEBOUNCE;
            col_nx  = low_idx(col_s);
            pat_n   = col_s;
          end else begin
            row_nx = row + 2'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s != pat) begin
          state_n = SCAN;
          cnt_n   = '0;
          row_nx  = row + 2'd1;
        end else if (cnt == DB_LAST) begin
          state_n  = HELD;
          cnt_n    = '0;
          kval_n   = key_code(row, col);
          kvalid_n = 1'b1;
          kheld_n  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          rcnt_n   = '0;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (col_s[col]) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rcnt == R_LAST) begin
          rcnt_n   = '0;
          kvalid_n = 1'b1;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
`ifdef KEYPAD_AUTOREPEAT_EN
        rcnt_n = '0;
`endif
        // a bounce back low resumes the hold silently
        if (!col_s[col]) begin
          state_n = HELD;
        end else if (cnt == DB_LAST) begin
          state_n = SCAN;
          cnt_n   = '0;
          kheld_n = 1'b0;
          row_nx  = row + 2'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  assign row_n         = ~(~ROW0_DRIVE << row);
  assign kp.keypad_val = kval;
  assign kp.key_valid  = kvalid;
  assign kp.key_held   = kheld;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan, debounce, ghosting and reset.
// A matrix model turns the pressed-key mask and row_n into col_n.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] pressed = '0;

  int compared = 0;
  int mism = 0;
  int vcount = 0;
  int badchg = 0;
  int v0;
  logic       prev_v = 1'b0;
  logic [7:0] prev_val = 8'h00;

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DB),
    .REPEAT_CNT   (RC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .col_n   (col_n),
    .row_n   (row_n),
    .kp      (kif)
  );

  always #5 clk = ~clk;

  // key index = row*4 + col; a driven row pulls pressed columns low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input string tag, input bit sel_held,
                          input logic lvl, input int maxc);
    int i;
    i = 0;
    while (((sel_held ? kif.key_held : kif.key_valid) !== lvl) && i < maxc) begin
      step(1);
      i++;
    end
    chk(tag, 32'((sel_held ? kif.key_held : kif.key_valid) === lvl), 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (!reset_n) begin
      prev_v   = 1'b0;
      prev_val = 8'h00;
    end else begin
      if (kif.key_valid) begin
        vcount++;
        chk("valid_b2b", 32'(prev_v), 32'd0);
      end else if (kif.keypad_val !== prev_val) begin
        badchg++;
      end
      prev_v   = kif.key_valid;
      prev_val = kif.keypad_val;
    end
  end

  initial begin
    // reset state and idle row rotation
    step(2);
    chk("rst_row", 32'(row_n), 32'h0E);
    chk("rst_val", 32'(kif.keypad_val), 32'h00);
    chk("rst_valid", 32'(kif.key_valid), 32'd0);
    chk("rst_held", 32'(kif.key_held), 32'd0);
    reset_n = 1'b1;
    chk("scan_r0", 32'(row_n), 32'h0E);
    step(4); chk("scan_r1", 32'(row_n), 32'h0D);
    step(4); chk("scan_r2", 32'(row_n), 32'h0B);
    step(4); chk("scan_r3", 32'(row_n), 32'h07);
    step(4); chk("scan_wrap", 32'(row_n), 32'h0E);
    chk("idle_novalid", 32'(vcount), 32'd0);

    // key 5, exact latency, hold and release
    pressed[5] = 1'b1;
    step(15);
    chk("k5_early_valid", 32'(kif.key_valid), 32'd0);
    chk("k5_early_val", 32'(kif.keypad_val), 32'h00);
    step(1);
    chk("k5_valid", 32'(kif.key_valid), 32'd1);
    chk("k5_val", 32'(kif.keypad_val), 32'h24);
    chk("k5_held", 32'(kif.key_held), 32'd1);
    chk("k5_row_frozen", 32'(row_n), 32'h0D);
    step(1);
    chk("k5_pulse_end", 32'(kif.key_valid), 32'd0);
    step(23);
    pressed[5] = 1'b0;
    step(10);
    chk("k5_held_rel", 32'(kif.key_held), 32'd1);
    step(1);
    chk("k5_released", 32'(kif.key_held), 32'd0);
    chk("k5_next_row", 32'(row_n), 32'h0B);
    chk("k5_one_pulse", 32'(vcount), 32'd1);

    // bouncing key 5
    reset_dut();
    v0 = vcount;
    for (int i = 0; i < 20; i++) begin
      pressed[5] = ((i / 3) % 2) == 0;
      step(1);
    end
    pressed[5] = 1'b1;
    wait_for("bnc_wait_valid", 1'b0, 1'b1, 200);
    chk("bnc_val", 32'(kif.keypad_val), 32'h24);
    step(30);
    chk("bnc_one_pulse", 32'(vcount - v0), 32'd1);
    chk("bnc_held", 32'(kif.key_held), 32'd1);
    pressed[5] = 1'b0;
    wait_for("bnc_wait_rel", 1'b1, 1'b0, 200);

    // F held, then 1 ignored until F released
    reset_dut();
    pressed[15] = 1'b1;
    wait_for("f_wait_valid", 1'b0, 1'b1, 200);
    chk("f_val", 32'(kif.keypad_val), 32'h81);
    v0 = vcount;
    pressed[0] = 1'b1;
    step(40);
    chk("f_keeps_val", 32'(kif.keypad_val), 32'h81);
    chk("f_no_new_pulse", 32'(vcount - v0), 32'd0);
    chk("f_held", 32'(kif.key_held), 32'd1);
    chk("f_row_frozen", 32'(row_n), 32'h07);
    pressed[15] = 1'b0;
    wait_for("f_wait_rel", 1'b1, 1'b0, 200);
    wait_for("k1_wait_valid", 1'b0, 1'b1, 200);
    chk("k1_val", 32'(kif.keypad_val), 32'h18);
    chk("k1_row", 32'(row_n), 32'h0E);
    pressed[0] = 1'b0;
    wait_for("k1_wait_rel", 1'b1, 1'b0, 200);

    // ghost: keys 4 and 6 on row1
    @(negedge clk);
    reset_n = 1'b0;
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    step(3);
    reset_n = 1'b1;
    v0 = vcount;
    step(4);  chk("gh_r1", 32'(row_n), 32'h0D);
    step(4);  chk("gh_r2", 32'(row_n), 32'h0B);
    step(8);  chk("gh_r0", 32'(row_n), 32'h0E);
    step(4);  chk("gh_r1_again", 32'(row_n), 32'h0D);
    step(4);  chk("gh_r2_again", 32'(row_n), 32'h0B);
    step(40);
    chk("gh_no_valid", 32'(vcount - v0), 32'd0);
    chk("gh_not_held", 32'(kif.key_held), 32'd0);
    pressed = '0;

    // key 0: reset during debounce, then full press
    @(negedge clk);
    reset_n = 1'b0;
    pressed[13] = 1'b1;
    step(3);
    reset_n = 1'b1;
    v0 = vcount;
    step(18);
    chk("k0_db_row", 32'(row_n), 32'h07);
    chk("k0_db_novalid", 32'(kif.key_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("k0_rst_row", 32'(row_n), 32'h0E);
    chk("k0_rst_val", 32'(kif.keypad_val), 32'h00);
    chk("k0_rst_valid", 32'(kif.key_valid), 32'd0);
    chk("k0_rst_held", 32'(kif.key_held), 32'd0);
    step(10);
    chk("k0_rst_no_pulse", 32'(vcount - v0), 32'd0);
    reset_n = 1'b1;
    step(23);
    chk("k0_early", 32'(kif.key_valid), 32'd0);
    step(1);
    chk("k0_valid", 32'(kif.key_valid), 32'd1);
    chk("k0_val", 32'(kif.keypad_val), 32'h84);
    step(15);
    chk("rep_gap", 32'(kif.key_valid), 32'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
    step(1);
    chk("rep_pulse1", 32'(kif.key_valid), 32'd1);
    chk("rep_val1", 32'(kif.keypad_val), 32'h84);
    step(16);
    chk("rep_pulse2", 32'(kif.key_valid), 32'd1);
    chk("rep_count", 32'(vcount - v0), 32'd3);
`else
    step(1);
    chk("norep_pulse1", 32'(kif.key_valid), 32'd0);
    step(16);
    chk("norep_pulse2", 32'(kif.key_valid), 32'd0);
    chk("norep_count", 32'(vcount - v0), 32'd1);
`endif
    pressed = '0;
    wait_for("k0_wait_rel", 1'b1, 1'b0, 200);

    chk("silent_val_change", 32'(badchg), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
